// File: rtl/mp_ram_ctrl.sv
// Multi-port register-file RAM with a post-reset clear sweep, lowest-port-wins
// write arbitration, registered reads and optional same-cycle write forwarding.
module mp_ram_ctrl #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRWIDTH    = 3,
  parameter int NUM_WR       = 2,
  parameter int NUM_RD       = 2,
  parameter int BYPASS       = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WR-1:0]             en_w_n,
  input  logic [NUM_WR*ADDRWIDTH-1:0]   addr_w,
  input  logic [NUM_WR*DATAWIDTH-1:0]   data_w,
  input  logic [NUM_RD-1:0]             en_r_n,
  input  logic [NUM_RD*ADDRWIDTH-1:0]   addr_r,
  output logic [NUM_RD*DATAWIDTH-1:0]   data_r,
  output logic [NUM_RD-1:0]             rvalid,
  output logic                          init_busy,
  output logic                          wr_collision
);

  // state    | meaning
  // ST_CLEAR | reset held or zero sweep running; all requests ignored
  // ST_READY | normal read/write service
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  localparam int DEPTH = 1 << ADDRWIDTH;

  state_t                       state_q, state_d;
  logic [ADDRWIDTH-1:0]         clr_ptr_q, clr_ptr_d;
  logic [DATAWIDTH-1:0]         mem_q [DEPTH];
  logic [NUM_RD*DATAWIDTH-1:0]  data_r_q, data_r_d;
  logic [NUM_RD-1:0]            rvalid_q, rvalid_d;
  logic                         wr_collision_q, collision;
  logic                         active, clr_we;
  logic [NUM_WR-1:0]            we;

  assign active = (state_q == ST_READY) && !rst;
  assign we     = active ? ~en_w_n : '0;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RST != 0) begin
          clr_we    = !rst;
          clr_ptr_d = clr_ptr_q + 1'b1;
          if (clr_ptr_q == {ADDRWIDTH{1'b1}}) state_d = ST_READY;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (we[i] && we[j] &&
            addr_w[i*ADDRWIDTH +: ADDRWIDTH] == addr_w[j*ADDRWIDTH +: ADDRWIDTH])
          collision = 1'b1;
      end
    end
  end

  // Forwarding scans ports high-to-low so the lowest-indexed writer is applied last.
  always_comb begin
    data_r_d = '0;
    rvalid_d = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (active && !en_r_n[j]) begin
        rvalid_d[j] = 1'b1;
        data_r_d[j*DATAWIDTH +: DATAWIDTH] = mem_q[addr_r[j*ADDRWIDTH +: ADDRWIDTH]];
        if (BYPASS != 0) begin
          for (int k = NUM_WR - 1; k >= 0; k--) begin
            if (we[k] && addr_w[k*ADDRWIDTH +: ADDRWIDTH] == addr_r[j*ADDRWIDTH +: ADDRWIDTH])
              data_r_d[j*DATAWIDTH +: DATAWIDTH] = data_w[k*DATAWIDTH +: DATAWIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_CLEAR;
      clr_ptr_q      <= '0;
      data_r_q       <= '0;
      rvalid_q       <= '0;
      wr_collision_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_ptr_q      <= clr_ptr_d;
      data_r_q       <= data_r_d;
      rvalid_q       <= rvalid_d;
      wr_collision_q <= collision;
    end
  end

  // Same-address writes: the last non-blocking update (lowest port) wins.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_ptr_q] <= '0;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      if (we[k]) mem_q[addr_w[k*ADDRWIDTH +: ADDRWIDTH]] <= data_w[k*DATAWIDTH +: DATAWIDTH];
    end
  end

  assign data_r       = data_r_q;
  assign rvalid       = rvalid_q;
  assign wr_collision = wr_collision_q;
  assign init_busy    = (state_q == ST_CLEAR) && (CLEAR_ON_RST != 0);

endmodule
